// File: rtl/peri_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-register-bus bridge.
package peri_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } br_state_e;

    typedef enum logic [1:0] {
        RESP_OK   = 2'd0,
        RESP_ERR  = 2'd1,
        RESP_DROP = 2'd2
    } br_resp_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_0BAD;

endpackage

// File: rtl/peri_reg_bridge_if.sv
// Wishbone-classic slave side plus register-bus master side of the bridge.
interface peri_reg_bridge_if #(
    parameter int AW = 11
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [AW-1:0] wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          wbs_err_o;

    logic          reg_cs;
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [3:0]    reg_be;
    logic [31:0]   reg_rdata;
    logic          reg_ack;

    // The bridge: Wishbone slave, register-bus master.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    // The environment: Wishbone master, register-bus slave.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/peri_reg_bridge.sv
// Registers one Wishbone transaction onto the peripheral register bus, with a
// timeout that answers with an error and records the first failing address.
module peri_reg_bridge
    import peri_bridge_pkg::*;
#(
    parameter int          AW          = 11,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic            mclk,
    input  logic            h_reset_n,
    peri_reg_bridge_if.slave bus,
    input  logic            err_clr,
    output logic            tout_flag,
    output logic [AW-1:0]   tout_addr
);

    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          aborted;

    logic          cs_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic          ack_q;
    logic          err_q;

    logic          req_start;
    logic          req_done;
    logic          tout_hit;
    br_resp_e      resp_next;

    assign req_start = (state == IDLE) && bus.wbs_cyc_i && bus.wbs_stb_i;
    assign req_done  = (state == REQ) && (bus.reg_ack || (cnt == CNT_LAST));
    assign tout_hit  = (state == REQ) && !bus.reg_ack && (cnt == CNT_LAST);

    // Ack beats a coinciding timeout; a master that left mid-transaction gets no response.
    always_comb begin
        resp_next = RESP_OK;
        if (aborted || !bus.wbs_cyc_i) begin
            resp_next = RESP_DROP;
        end else if (!bus.reg_ack) begin
            resp_next = RESP_ERR;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            aborted <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_start) begin
                        state   <= REQ;
                        cs_q    <= 1'b1;
                        wr_q    <= bus.wbs_we_i;
                        addr_q  <= bus.wbs_adr_i;
                        wdata_q <= bus.wbs_dat_i;
                        be_q    <= bus.wbs_sel_i;
                        cnt     <= '0;
                        aborted <= 1'b0;
                    end
                end
                REQ: begin
                    if (!bus.wbs_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    if (req_done) begin
                        state <= RESP;
                        cs_q  <= 1'b0;
                        ack_q <= (resp_next == RESP_OK);
                        err_q <= (resp_next == RESP_ERR);
                        if (!bus.reg_ack) begin
                            rdata_q <= ERR_DATA;
                        end else if (!wr_q) begin
                            rdata_q <= bus.reg_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // First timeout wins, except that a clear in the same cycle lets the new one in.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            tout_flag <= 1'b0;
            tout_addr <= '0;
        end else if (tout_hit && (!tout_flag || err_clr)) begin
            tout_flag <= 1'b1;
            tout_addr <= addr_q;
        end else if (err_clr) begin
            tout_flag <= 1'b0;
            tout_addr <= '0;
        end
    end

    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_be    = be_q;
    assign bus.wbs_dat_o = rdata_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;

endmodule

// File: tb/tb_peri_reg_bridge.sv
// Directed and randomized transactions against a transaction-level model of the bridge.
module tb_peri_reg_bridge;

    localparam int          AW       = 11;
    localparam int          T        = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_0BAD;

    logic          mclk      = 1'b0;
    logic          h_reset_n = 1'b0;
    logic          err_clr   = 1'b0;
    logic          tout_flag;
    logic [AW-1:0] tout_addr;

    int vectors;
    int miscompares;

    // Transaction-level model: last read data seen by the master and sticky status.
    logic [31:0]   m_dat;
    logic          m_flag;
    logic [AW-1:0] m_addr;

    peri_reg_bridge_if #(.AW(AW)) bus ();

    peri_reg_bridge #(
        .AW          (AW),
        .TIMEOUT_CYC (T),
        .ERR_DATA    (ERR_DATA)
    ) dut (
        .mclk      (mclk),
        .h_reset_n (h_reset_n),
        .bus       (bus.slave),
        .err_clr   (err_clr),
        .tout_flag (tout_flag),
        .tout_addr (tout_addr)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_cs"},    32'(bus.reg_cs),    32'h0);
        check({pfx, "_wr"},    32'(bus.reg_wr),    32'h0);
        check({pfx, "_addr"},  32'(bus.reg_addr),  32'h0);
        check({pfx, "_wdata"}, bus.reg_wdata,      32'h0);
        check({pfx, "_be"},    32'(bus.reg_be),    32'h0);
        check({pfx, "_ack"},   32'(bus.wbs_ack_o), 32'h0);
        check({pfx, "_err"},   32'(bus.wbs_err_o), 32'h0);
        check({pfx, "_dat"},   bus.wbs_dat_o,      32'h0);
        check({pfx, "_flag"},  32'(tout_flag),     32'h0);
        check({pfx, "_taddr"}, 32'(tout_addr),     32'h0);
    endtask

    task automatic idle_gap(input logic clr);
        @(posedge mclk); #1;
        err_clr = clr;
        @(posedge mclk); #1;
        err_clr = 1'b0;
        if (clr) begin
            m_flag = 1'b0;
            m_addr = '0;
        end
        @(negedge mclk);
        check("idle_flag", 32'(tout_flag), 32'(m_flag));
        check("idle_taddr", 32'(tout_addr), 32'(m_addr));
        check("idle_cs", 32'(bus.reg_cs), 32'h0);
    endtask

    // One Wishbone transaction. ack_cyc = cycle in which the slave acks (0: never),
    // abort_cyc = cycle in which the master drops cyc (0: never), clr = err_clr on the
    // last request cycle. Cycle k is the period ending at edge k; the request is
    // presented in cycle 0.
    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_cyc, input int abort_cyc,
                           input logic [31:0] rdata, input logic clr);
        logic          ok;
        logic          aborted;
        int            last;
        logic [31:0]   n_dat;
        logic          n_flag;
        logic [AW-1:0] n_addr;
        logic          in_req;
        logic          resp;

        ok      = (ack_cyc >= 1) && (ack_cyc <= T);
        last    = ok ? ack_cyc : T;
        aborted = (abort_cyc >= 1);
        n_dat   = m_dat;
        n_flag  = m_flag;
        n_addr  = m_addr;
        if (ok) begin
            if (!we) n_dat = rdata;
        end else begin
            n_dat = ERR_DATA;
        end
        if (!ok && (!m_flag || clr)) begin
            n_flag = 1'b1;
            n_addr = adr;
        end else if (clr) begin
            n_flag = 1'b0;
            n_addr = '0;
        end

        @(posedge mclk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;

        for (int c = 1; c <= last + 2; c++) begin
            @(posedge mclk); #1;
            bus.reg_ack   = (c == ack_cyc);
            bus.reg_rdata = (c == ack_cyc) ? rdata : $urandom();
            err_clr       = clr && (c == last);
            if (c == abort_cyc || c == last + 1) begin
                bus.wbs_cyc_i = 1'b0;
                bus.wbs_stb_i = 1'b0;
                bus.wbs_adr_i = AW'($urandom());
                bus.wbs_dat_i = $urandom();
            end
            @(negedge mclk);
            in_req = (c <= last);
            resp   = (c == last + 1);
            check("reg_cs", 32'(bus.reg_cs), 32'(in_req));
            check("wbs_ack", 32'(bus.wbs_ack_o), 32'(resp && ok && !aborted));
            check("wbs_err", 32'(bus.wbs_err_o), 32'(resp && !ok && !aborted));
            if (in_req) begin
                check("reg_wr", 32'(bus.reg_wr), 32'(we));
                check("reg_addr", 32'(bus.reg_addr), 32'(adr));
                check("reg_wdata", bus.reg_wdata, dat);
                check("reg_be", 32'(bus.reg_be), 32'(sel));
            end
            check("wbs_dat", bus.wbs_dat_o, in_req ? m_dat : n_dat);
            check("tout_flag", 32'(tout_flag), 32'(in_req ? m_flag : n_flag));
            check("tout_addr", 32'(tout_addr), 32'(in_req ? m_addr : n_addr));
        end
        bus.reg_ack = 1'b0;
        err_clr     = 1'b0;
        m_dat  = n_dat;
        m_flag = n_flag;
        m_addr = n_addr;
    endtask

    initial begin
        int ack;
        int lst;
        int abt;

        vectors     = 0;
        miscompares = 0;
        m_dat  = '0;
        m_flag = 1'b0;
        m_addr = '0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_sel_i = '0;
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = '0;

        repeat (2) @(posedge mclk);
        @(negedge mclk);
        check_reset_values("rst");
        @(posedge mclk); #1;
        h_reset_n = 1'b1;

        // Read acked in cycle 2.
        run_txn(1'b0, 11'h010, 32'h0, 4'hF, 2, 0, 32'h1234_5678, 1'b0);
        // Write acked in cycle 3.
        run_txn(1'b1, 11'h084, 32'hA5A5_0001, 4'b0011, 3, 0, 32'h0BAD_F00D, 1'b0);
        // Three timeouts: first sets, second is ignored, third coincides with a clear.
        run_txn(1'b0, 11'h1F0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 11'h2AA, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 11'h155, 32'h0, 4'hF, 0, 0, 32'h0, 1'b1);
        // Ack arrives on the last allowed cycle.
        run_txn(1'b0, 11'h300, 32'h0, 4'hF, T, 0, 32'hCAFE_0042, 1'b0);
        // Master abort in cycle 2, slave ack in cycle 4, then a normal read.
        run_txn(1'b0, 11'h044, 32'h0, 4'hF, 4, 2, 32'h7777_1111, 1'b0);
        run_txn(1'b0, 11'h048, 32'h0, 4'hF, 1, 0, 32'h2468_ACE0, 1'b0);
        idle_gap(1'b1);

        for (int i = 0; i < 40; i++) begin
            ack = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, T + 2));
            lst = (ack >= 1 && ack <= T) ? ack : T;
            abt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lst)) : 0;
            run_txn(1'($urandom()), AW'($urandom()), $urandom(), 4'($urandom()),
                    ack, abt, $urandom(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_gap(1'($urandom()));
        end

        // Leave the sticky flag set, then reset in the middle of a request.
        run_txn(1'b0, 11'h0F0, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0);
        @(posedge mclk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = 11'h3C3;
        bus.wbs_dat_i = 32'h5555_AAAA;
        bus.wbs_sel_i = 4'hF;
        @(posedge mclk); #1;
        @(negedge mclk);
        check("pre_rst_cs", 32'(bus.reg_cs), 32'h1);
        #2;
        h_reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(posedge mclk); #1;
        h_reset_n = 1'b1;
        m_dat  = '0;
        m_flag = 1'b0;
        m_addr = '0;
        @(negedge mclk);
        check_reset_values("post_rst");
        run_txn(1'b0, 11'h3C4, 32'h0, 4'hF, 1, 0, 32'h9ABC_DEF0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
